barrel_sft: RTL and testbench



---
 rtl/barrel_sft.sv | 43 ++++
 tb/tb_barrel_sft.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/barrel_sft.sv
// Registered logical barrel shifter: log2 mux network of SHW stages, one result per clock.
// Output register clears synchronously when rst_n is low.
module barrel_sft #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    input  logic             direction,
    output logic [WIDTH-1:0] out
);

    logic [SHW:0][WIDTH-1:0] stage;

    assign stage[0] = in;

    // Stage k moves the word by 2^k positions when shift[k] is set; vacated bits are zero.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] shl;
        logic [WIDTH-1:0] shr;

        assign shl = stage[k] << (2 ** k);
        assign shr = stage[k] >> (2 ** k);

        always_comb begin
            stage[k+1] = stage[k];
            if (shift[k]) begin
                stage[k+1] = direction ? shl : shr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= stage[SHW];
        end
    end

endmodule

// File: tb/tb_barrel_sft.sv
// Directed and random checks of barrel_sft: reset, left/right shifts, zero shift,
// extremes, back-to-back streaming and a mid-stream reset pulse.
module tb_barrel_sft;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic [2:0] shift;
    logic       direction;
    logic [7:0] out;

    int vectors;
    int miscompares;

    barrel_sft #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .shift     (shift),
        .direction (direction),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands on the falling edge, then let the next rising edge capture them.
    task automatic drive(input logic r, input logic [7:0] d, input logic [2:0] s, input logic dir);
        @(negedge clk);
        rst_n     = r;
        in        = d;
        shift     = s;
        direction = dir;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'hFF, 3'd3, 1'b1);
        vectors++;
        if (out !== 8'h00) begin
            $display("FAIL reset_edge1 out=%h expected=%h", out, 8'h00);
            miscompares++;
        end
        drive(1'b0, 8'hFF, 3'd3, 1'b1);
        vectors++;
        if (out !== 8'h00) begin
            $display("FAIL reset_edge2 out=%h expected=%h", out, 8'h00);
            miscompares++;
        end
        drive(1'b1, 8'hFF, 3'd3, 1'b1);
        vectors++;
        if (out !== 8'hF8) begin
            $display("FAIL reset_release out=%h expected=%h", out, 8'hF8);
            miscompares++;
        end
    endtask

    task automatic test_left();
        drive(1'b1, 8'b10101101, 3'd6, 1'b1);
        vectors++;
        if (out !== 8'b01000000) begin
            $display("FAIL left_6 out=%b expected=%b", out, 8'b01000000);
            miscompares++;
        end
        drive(1'b1, 8'b10101101, 3'd3, 1'b1);
        vectors++;
        if (out !== 8'b01101000) begin
            $display("FAIL left_3 out=%b expected=%b", out, 8'b01101000);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'b10101101, 3'd2, 1'b0);
        vectors++;
        if (out !== 8'b00101011) begin
            $display("FAIL right_2 out=%b expected=%b", out, 8'b00101011);
            miscompares++;
        end
        drive(1'b1, 8'b10101101, 3'd1, 1'b0);
        vectors++;
        if (out !== 8'b01010110) begin
            $display("FAIL right_1 out=%b expected=%b", out, 8'b01010110);
            miscompares++;
        end
        drive(1'b1, 8'b10101101, 3'd4, 1'b0);
        vectors++;
        if (out !== 8'b00001010) begin
            $display("FAIL right_4 out=%b expected=%b", out, 8'b00001010);
            miscompares++;
        end
    endtask

    task automatic test_zero_shift();
        drive(1'b1, 8'b10101101, 3'd0, 1'b1);
        vectors++;
        if (out !== 8'b10101101) begin
            $display("FAIL zero_left out=%b expected=%b", out, 8'b10101101);
            miscompares++;
        end
        drive(1'b1, 8'b10101101, 3'd0, 1'b0);
        vectors++;
        if (out !== 8'b10101101) begin
            $display("FAIL zero_right out=%b expected=%b", out, 8'b10101101);
            miscompares++;
        end
    endtask

    task automatic test_extremes();
        drive(1'b1, 8'h81, 3'd7, 1'b1);
        vectors++;
        if (out !== 8'h80) begin
            $display("FAIL ext_81_left out=%h expected=%h", out, 8'h80);
            miscompares++;
        end
        drive(1'b1, 8'h81, 3'd7, 1'b0);
        vectors++;
        if (out !== 8'h01) begin
            $display("FAIL ext_81_right out=%h expected=%h", out, 8'h01);
            miscompares++;
        end
        drive(1'b1, 8'hFF, 3'd7, 1'b1);
        vectors++;
        if (out !== 8'h80) begin
            $display("FAIL ext_ff_left out=%h expected=%h", out, 8'h80);
            miscompares++;
        end
        drive(1'b1, 8'hFF, 3'd7, 1'b0);
        vectors++;
        if (out !== 8'h01) begin
            $display("FAIL ext_ff_right out=%h expected=%h", out, 8'h01);
            miscompares++;
        end
        drive(1'b1, 8'hFF, 3'd5, 1'b0);
        vectors++;
        if (out !== 8'h07) begin
            $display("FAIL ff_right_5 out=%h expected=%h", out, 8'h07);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [2:0] s;
        logic       dir;
        logic       r;
        logic [7:0] exp_out;
        for (int i = 0; i < 1000; i++) begin
            d   = 8'($urandom_range(0, 255));
            s   = 3'($urandom_range(0, 7));
            dir = 1'($urandom_range(0, 1));
            r   = (i == 500 || i == 501) ? 1'b0 : 1'b1;
            if (!r)
                exp_out = 8'h00;
            else if (dir)
                exp_out = d << s;
            else
                exp_out = d >> s;
            drive(r, d, s, dir);
            vectors++;
            if (out !== exp_out) begin
                $display("FAIL random[%0d] in=%h shift=%0d dir=%b rst_n=%b out=%h expected=%h",
                         i, d, s, dir, r, out, exp_out);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in          = 8'h00;
        shift       = 3'd0;
        direction   = 1'b0;

        test_reset();
        test_left();
        test_back_to_back();
        test_zero_shift();
        test_extremes();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
